// File: rtl/saturn_bus_ctrl_pkg.sv
// Shared definitions for the Saturn nibble-bus master: bus command codes,
// controller state encodings and the device read-mode shadow encoding.
package saturn_bus_ctrl_pkg;

    // Bus command nibbles, driven while o_bus_is_data is low.
    localparam logic [3:0] BUSCMD_PC_READ = 4'h0;
    localparam logic [3:0] BUSCMD_DP_READ = 4'h1;
    localparam logic [3:0] BUSCMD_LOAD_PC = 4'h4;
    localparam logic [3:0] BUSCMD_LOAD_DP = 4'h5;

    // A pointer load carries the 20-bit address as five nibbles, LSN first.
    localparam int ADDR_NIBBLES = 5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_DATA,
        ST_LAST,
        ST_DONE
    } bus_state_t;

    typedef enum logic [1:0] {
        BUS_MODE_NONE,
        BUS_MODE_PC,
        BUS_MODE_DP
    } bus_mode_t;

    function automatic logic [3:0] addr_nibble(input logic [19:0] addr, input logic [2:0] idx);
        return addr[idx*4 +: 4];
    endfunction

endpackage

// File: rtl/saturn_bus_slot_timer.sv
// Free-running bus slot timer: phase counter, slot strobe on the last phase,
// and a one-clock-delayed strobe marking when device read data is valid.
module saturn_bus_slot_timer #(
    parameter int BUS_PERIOD = 4
) (
    input  logic i_clk,
    input  logic i_reset,
    output logic o_strobe,
    output logic o_strobe_d1
);

    localparam int CW = $clog2(BUS_PERIOD);
    localparam logic [CW-1:0] PHASE_LAST = CW'(BUS_PERIOD - 1);

    logic [CW-1:0] phase;

    // Phase counter wraps every BUS_PERIOD clocks; delayed strobe follows it.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            phase       <= '0;
            o_strobe_d1 <= 1'b0;
        end else begin
            phase       <= (phase == PHASE_LAST) ? '0 : phase + 1'b1;
            o_strobe_d1 <= o_strobe;
        end
    end

    assign o_strobe = (phase == PHASE_LAST);

endmodule

// File: rtl/saturn_bus_ctrl.sv
// Saturn nibble-bus master. Turns PC/DP-relative nibble read requests into
// slot-timed command, address and data cycles, and shadows each device
// pointer and the device read mode to skip redundant pointer loads.
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | ready for a request; bus outputs parked at zero
// CMD     | command slot (LOAD_PC/LOAD_DP or PC_READ/DP_READ) on the bus
// ADDR    | one of five address slots, LSN first
// DATA    | data slot; device returns a nibble, shadow pointer advances
// LAST    | final data slot strobed, waiting for its nibble to be captured
// DONE    | one clock gap so ready rises after the final o_rd_valid
module saturn_bus_ctrl
    import saturn_bus_ctrl_pkg::*;
#(
    parameter int BUS_PERIOD = 4
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic        i_req_is_dp,
    input  logic [19:0] i_req_addr,
    input  logic [3:0]  i_req_count,
    output logic        o_rd_valid,
    output logic [3:0]  o_rd_nibble,
    output logic        o_busy,
    output logic        o_bus_clk_en,
    output logic        o_bus_is_data,
    output logic [3:0]  o_bus_nibble_out,
    input  logic [3:0]  i_bus_nibble_in
);

    bus_state_t  state;
    bus_mode_t   mode;
    logic [19:0] shadow_pc;
    logic [19:0] shadow_dp;
    logic        shadow_pc_ok;
    logic        shadow_dp_ok;
    logic [19:0] addr_q;
    logic        is_dp_q;
    logic        full_q;
    logic [2:0]  addr_idx;
    logic [4:0]  remain;
    logic        cap_pend;
    logic        strobe;
    logic        strobe_d1;

    logic        accept;
    logic        ptr_hit;
    bus_mode_t   req_mode;

    saturn_bus_slot_timer #(
        .BUS_PERIOD (BUS_PERIOD)
    ) u_slot_timer (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .o_strobe    (strobe),
        .o_strobe_d1 (strobe_d1)
    );

    assign o_bus_clk_en = strobe;

    // Classify an incoming request against the shadow of the chosen pointer.
    always_comb begin
        accept   = i_req_valid && o_req_ready;
        req_mode = i_req_is_dp ? BUS_MODE_DP : BUS_MODE_PC;
        ptr_hit  = 1'b0;
        if (i_req_is_dp)
            ptr_hit = shadow_dp_ok && (i_req_addr == shadow_dp);
        else
            ptr_hit = shadow_pc_ok && (i_req_addr == shadow_pc);
    end

    // Transaction FSM, shadow registers and registered bus/read outputs.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state            <= ST_IDLE;
            mode             <= BUS_MODE_NONE;
            shadow_pc        <= '0;
            shadow_dp        <= '0;
            shadow_pc_ok     <= 1'b0;
            shadow_dp_ok     <= 1'b0;
            addr_q           <= '0;
            is_dp_q          <= 1'b0;
            full_q           <= 1'b0;
            addr_idx         <= '0;
            remain           <= '0;
            cap_pend         <= 1'b0;
            o_req_ready      <= 1'b1;
            o_busy           <= 1'b0;
            o_rd_valid       <= 1'b0;
            o_rd_nibble      <= '0;
            o_bus_is_data    <= 1'b0;
            o_bus_nibble_out <= '0;
        end else begin
            // Device registers its nibble on the strobe; it is safe to take one clock later.
            o_rd_valid <= 1'b0;
            if (strobe_d1 && cap_pend) begin
                o_rd_valid  <= 1'b1;
                o_rd_nibble <= i_bus_nibble_in;
                cap_pend    <= 1'b0;
            end

            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        o_req_ready <= 1'b0;
                        o_busy      <= 1'b1;
                        addr_q      <= i_req_addr;
                        is_dp_q     <= i_req_is_dp;
                        addr_idx    <= '0;
                        remain      <= (i_req_count == 4'd0) ? 5'd16 : {1'b0, i_req_count};
                        mode        <= req_mode;
                        if (!ptr_hit) begin
                            // Device enters the matching read mode after the 5th address nibble.
                            full_q           <= 1'b1;
                            state            <= ST_CMD;
                            o_bus_is_data    <= 1'b0;
                            o_bus_nibble_out <= i_req_is_dp ? BUSCMD_LOAD_DP : BUSCMD_LOAD_PC;
                            if (i_req_is_dp) begin
                                shadow_dp    <= i_req_addr;
                                shadow_dp_ok <= 1'b1;
                            end else begin
                                shadow_pc    <= i_req_addr;
                                shadow_pc_ok <= 1'b1;
                            end
                        end else if (mode != req_mode) begin
                            full_q           <= 1'b0;
                            state            <= ST_CMD;
                            o_bus_is_data    <= 1'b0;
                            o_bus_nibble_out <= i_req_is_dp ? BUSCMD_DP_READ : BUSCMD_PC_READ;
                        end else begin
                            full_q           <= 1'b0;
                            state            <= ST_DATA;
                            o_bus_is_data    <= 1'b1;
                            o_bus_nibble_out <= '0;
                        end
                    end
                end

                ST_CMD: begin
                    if (strobe) begin
                        o_bus_is_data <= 1'b1;
                        if (full_q) begin
                            state            <= ST_ADDR;
                            o_bus_nibble_out <= addr_nibble(addr_q, 3'd0);
                        end else begin
                            state            <= ST_DATA;
                            o_bus_nibble_out <= '0;
                        end
                    end
                end

                ST_ADDR: begin
                    if (strobe) begin
                        if (addr_idx == 3'(ADDR_NIBBLES - 1)) begin
                            state            <= ST_DATA;
                            o_bus_nibble_out <= '0;
                        end else begin
                            addr_idx         <= addr_idx + 3'd1;
                            o_bus_nibble_out <= addr_nibble(addr_q, addr_idx + 3'd1);
                        end
                    end
                end

                ST_DATA: begin
                    if (strobe) begin
                        cap_pend <= 1'b1;
                        remain   <= remain - 5'd1;
                        if (is_dp_q)
                            shadow_dp <= shadow_dp + 20'd1;
                        else
                            shadow_pc <= shadow_pc + 20'd1;
                        if (remain == 5'd1) begin
                            state            <= ST_LAST;
                            o_bus_is_data    <= 1'b0;
                            o_bus_nibble_out <= '0;
                        end
                    end
                end

                ST_LAST: begin
                    if (strobe_d1)
                        state <= ST_DONE;
                end

                ST_DONE: begin
                    state       <= ST_IDLE;
                    o_req_ready <= 1'b1;
                    o_busy      <= 1'b0;
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_saturn_bus_ctrl.sv
// Directed bench for saturn_bus_ctrl with a ROM device model on the bus.
module tb_saturn_bus_ctrl;

    localparam logic [3:0] C_PC_READ = 4'h0;
    localparam logic [3:0] C_DP_READ = 4'h1;
    localparam logic [3:0] C_LOAD_PC = 4'h4;
    localparam logic [3:0] C_LOAD_DP = 4'h5;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_is_dp = 1'b0;
    logic [19:0] req_addr = '0;
    logic [3:0]  req_count = '0;
    logic        rd_valid;
    logic [3:0]  rd_nibble;
    logic        busy;
    logic        bus_clk_en;
    logic        bus_is_data;
    logic [3:0]  bus_out;
    logic [3:0]  bus_in;

    int n_checks = 0;
    int n_errors = 0;

    logic [4:0] slot_q[$];
    logic [3:0] rd_q[$];

    always #5 clk = ~clk;

    saturn_bus_ctrl #(.BUS_PERIOD(4)) dut (
        .i_clk            (clk),
        .i_reset          (rst),
        .i_req_valid      (req_valid),
        .o_req_ready      (req_ready),
        .i_req_is_dp      (req_is_dp),
        .i_req_addr       (req_addr),
        .i_req_count      (req_count),
        .o_rd_valid       (rd_valid),
        .o_rd_nibble      (rd_nibble),
        .o_busy           (busy),
        .o_bus_clk_en     (bus_clk_en),
        .o_bus_is_data    (bus_is_data),
        .o_bus_nibble_out (bus_out),
        .i_bus_nibble_in  (bus_in)
    );

    function automatic logic [3:0] rom_nib(input logic [19:0] a);
        return a[3:0] ^ a[7:4] ^ a[11:8] ^ a[15:12] ^ a[19:16] ^ 4'hA;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ROM device model plus slot/read logging, all sampled mid-cycle.
    logic [19:0] dev_pc = '0;
    logic [19:0] dev_dp = '0;
    int          dev_mode = 0;
    int          dev_cnt = 0;

    always @(negedge clk) begin
        if (rst) begin
            dev_mode = 0;
            bus_in   = 4'h0;
        end else begin
            if (busy && bus_clk_en) begin
                slot_q.push_back({bus_is_data, bus_out});
                if (!bus_is_data) begin
                    case (bus_out)
                        C_PC_READ: dev_mode = 1;
                        C_DP_READ: dev_mode = 2;
                        C_LOAD_PC: begin dev_mode = 3; dev_cnt = 0; end
                        C_LOAD_DP: begin dev_mode = 4; dev_cnt = 0; end
                        default:   dev_mode = 0;
                    endcase
                end else begin
                    case (dev_mode)
                        1: begin bus_in = rom_nib(dev_pc); dev_pc = dev_pc + 20'd1; end
                        2: begin bus_in = rom_nib(dev_dp); dev_dp = dev_dp + 20'd1; end
                        3: begin
                            dev_pc[dev_cnt*4 +: 4] = bus_out;
                            dev_cnt++;
                            if (dev_cnt == 5) dev_mode = 1;
                        end
                        4: begin
                            dev_dp[dev_cnt*4 +: 4] = bus_out;
                            dev_cnt++;
                            if (dev_cnt == 5) dev_mode = 2;
                        end
                        default: ;
                    endcase
                end
            end
            if (rd_valid) rd_q.push_back(rd_nibble);
        end
    end

    // hdr: 0 data only, 1 full pointer load, 2 read-mode switch command.
    task automatic xfer(input string tag, input bit dp, input logic [19:0] a,
                        input logic [3:0] c, input int hdr, input int exp_slots);
        int to;
        int bad;
        int n;
        logic [4:0] exp_q[$];
        logic [19:0] tmp;
        logic [31:0] got;
        @(negedge clk);
        to = 0;
        while (!req_ready && to < 500) begin @(negedge clk); to++; end
        slot_q.delete();
        rd_q.delete();
        req_valid = 1'b1; req_is_dp = dp; req_addr = a; req_count = c;
        @(negedge clk);
        req_valid = 1'b0;
        check({tag, "/accepted"}, {31'd0, busy}, 32'd1);
        to = 0; bad = 0;
        while (!req_ready && to < 500) begin
            if (busy === req_ready) bad++;
            @(negedge clk);
            to++;
        end
        check({tag, "/done"}, {31'd0, (to < 500)}, 32'd1);
        check({tag, "/busy_ready"}, bad, 0);
        n = (c == 4'd0) ? 16 : int'(c);
        if (hdr == 1) begin
            exp_q.push_back({1'b0, dp ? C_LOAD_DP : C_LOAD_PC});
            tmp = a;
            for (int i = 0; i < 5; i++) begin
                exp_q.push_back({1'b1, tmp[3:0]});
                tmp = tmp >> 4;
            end
        end else if (hdr == 2) begin
            exp_q.push_back({1'b0, dp ? C_DP_READ : C_PC_READ});
        end
        for (int i = 0; i < n; i++) exp_q.push_back(5'h10);
        check({tag, "/slots"}, slot_q.size(), exp_slots);
        for (int i = 0; i < exp_q.size(); i++) begin
            got = (i < slot_q.size()) ? {27'd0, slot_q[i]} : 32'hDEAD;
            check($sformatf("%s/slot%0d", tag, i), got, {27'd0, exp_q[i]});
        end
        check({tag, "/rd_count"}, rd_q.size(), n);
        for (int i = 0; i < n; i++) begin
            got = (i < rd_q.size()) ? {28'd0, rd_q[i]} : 32'hDEAD;
            check($sformatf("%s/rd%0d", tag, i), got, {28'd0, rom_nib(a + 20'(i))});
        end
    endtask

    initial begin
        int k;
        int first_s;
        int second_s;
        int to;
        int bad;
        int pulses;
        logic [3:0] a0;
        logic [3:0] a1;

        repeat (3) @(negedge clk);
        check("reset/ready", {31'd0, req_ready}, 32'd1);
        check("reset/busy", {31'd0, busy}, 32'd0);
        check("reset/clk_en", {31'd0, bus_clk_en}, 32'd0);
        check("reset/rd_valid", {31'd0, rd_valid}, 32'd0);
        check("reset/is_data", {31'd0, bus_is_data}, 32'd0);
        check("reset/nibble", {28'd0, bus_out}, 32'd0);
        rst = 1'b0;

        first_s = 0; second_s = 0;
        for (k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (bus_clk_en) begin
                if (first_s == 0) first_s = k;
                else if (second_s == 0) second_s = k;
            end
        end
        check("strobe/first", first_s, 3);
        check("strobe/second", second_s, 7);

        xfer("pc100", 1'b0, 20'h00100, 4'd2, 1, 8);
        xfer("pc102", 1'b0, 20'h00102, 4'd1, 0, 1);
        xfer("dp200", 1'b1, 20'h00200, 4'd1, 1, 7);
        xfer("pc103", 1'b0, 20'h00103, 4'd1, 2, 2);
        xfer("dpwrap", 1'b1, 20'hFFFFE, 4'd0, 1, 22);
        xfer("dp00E", 1'b1, 20'h0000E, 4'd1, 0, 1);
        xfer("pc104", 1'b0, 20'h00104, 4'd1, 2, 2);

        // Request held valid across a transfer; fields change after acceptance.
        @(negedge clk);
        to = 0;
        while (!req_ready && to < 500) begin @(negedge clk); to++; end
        slot_q.delete(); rd_q.delete();
        req_valid = 1'b1; req_is_dp = 1'b0; req_addr = 20'h00105; req_count = 4'd2;
        @(negedge clk);
        req_is_dp = 1'b1; req_addr = 20'h0000F; req_count = 4'd1;
        to = 0; bad = 0; pulses = 0;
        while (!(req_ready && pulses >= 2) && to < 500) begin
            if (req_ready) bad++;
            if (rd_valid) pulses++;
            @(negedge clk);
            to++;
        end
        check("held/done", {31'd0, (to < 500)}, 32'd1);
        check("held/ready_low", bad, 0);
        check("held/a_slots", slot_q.size(), 2);
        a0 = (rd_q.size() > 0) ? rd_q[0] : 4'hX;
        a1 = (rd_q.size() > 1) ? rd_q[1] : 4'hX;
        check("held/a_rd0", {28'd0, a0}, {28'd0, rom_nib(20'h00105)});
        check("held/a_rd1", {28'd0, a1}, {28'd0, rom_nib(20'h00106)});
        slot_q.delete(); rd_q.delete();
        @(negedge clk);
        req_valid = 1'b0;
        check("held/b_accepted", {31'd0, busy}, 32'd1);
        to = 0;
        while (!req_ready && to < 500) begin @(negedge clk); to++; end
        check("held/b_done", {31'd0, (to < 500)}, 32'd1);
        check("held/b_slots", slot_q.size(), 2);
        check("held/b_cmd", (slot_q.size() > 0) ? {27'd0, slot_q[0]} : 32'hDEAD, {27'd0, 1'b0, C_DP_READ});
        check("held/b_rd", (rd_q.size() > 0) ? {28'd0, rd_q[0]} : 32'hDEAD, {28'd0, rom_nib(20'h0000F)});

        // Reset during the third address slot of a full load.
        @(negedge clk);
        slot_q.delete(); rd_q.delete();
        req_valid = 1'b1; req_is_dp = 1'b0; req_addr = 20'h00300; req_count = 4'd2;
        @(negedge clk);
        req_valid = 1'b0;
        k = 0; to = 0;
        while (k < 4 && to < 200) begin
            if (busy && bus_clk_en) k++;
            if (k < 4) begin @(negedge clk); to++; end
        end
        check("abort/reach_addr3", k, 4);
        rst = 1'b1;
        @(negedge clk);
        check("abort/ready", {31'd0, req_ready}, 32'd1);
        check("abort/busy", {31'd0, busy}, 32'd0);
        check("abort/is_data", {31'd0, bus_is_data}, 32'd0);
        check("abort/nibble", {28'd0, bus_out}, 32'd0);
        check("abort/rd_valid", {31'd0, rd_valid}, 32'd0);
        rst = 1'b0;
        pulses = 0;
        repeat (20) begin
            @(negedge clk);
            if (rd_valid) pulses++;
        end
        check("abort/no_rd", pulses, 0);
        xfer("post_reset", 1'b0, 20'h00100, 4'd1, 1, 7);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
